// File: rtl/sensor_frame_pkg.sv
// Shared constants and types for the sensor frame store-and-forward FIFO.
package sensor_frame_pkg;

    localparam logic [31:0] HEADER = 32'hAAAA_AAAA;
    localparam logic [31:0] FOOTER = 32'h5555_5555;
    localparam logic [31:0] TERM   = 32'hBBBB_BBBB;

    typedef enum logic [1:0] {HUNT, BODY, DROP} wr_state_t;

    // What the write side does with the word on s_tdata this cycle.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_SYNC,
        ACT_OPEN,
        ACT_SINGLE,
        ACT_APPEND,
        ACT_CLOSE,
        ACT_RESYNC,
        ACT_ABORT
    } wr_act_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sensor_frame_buffer_if.sv
// Upstream (packetizer) and downstream (DMA) stream signals of the frame buffer.
interface sensor_frame_buffer_if;

    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );

endinterface

// File: rtl/sensor_frame_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable (holds q when idle).
module sensor_frame_ram #(
    parameter int AW = 10,
    parameter int DW = 33
) (
    input  logic          master_clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge master_clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/sensor_frame_buffer.sv
// Store-and-forward frame FIFO: speculative writes per frame, release on FOOTER, rollback on error.
module sensor_frame_buffer
    import sensor_frame_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_WORDS  = 600
) (
    input  logic                 master_clock,
    input  logic                 resetn,
    sensor_frame_buffer_if.slave bus,
    input  logic                 clear_stats,
    output logic [DEPTH_LOG2:0]  fill_level,
    output logic [15:0]          frames_committed,
    output logic [15:0]          frames_dropped,
    output logic [15:0]          sync_errors
);

    localparam int              PW       = DEPTH_LOG2 + 1;
    localparam int              LW       = $clog2(MAX_WORDS + 1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   CAPACITY = PW'(1) << DEPTH_LOG2;

    wr_state_t             state;
    wr_act_t               act;
    logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr;
    logic [LW-1:0]         frame_len;
    logic                  full, is_hdr, is_ftr;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [32:0]           ram_q;
    logic                  rd_pend, rd_en, load;
    logic                  out_vld, out_last;
    logic [31:0]           out_data;

    assign bus.s_tready = 1'b1;
    assign fill_level   = wr_ptr - rd_ptr;

    // Pending (uncommitted) words count toward full, so a frame can never spill onto committed data.
    always_comb begin
        full   = (wr_ptr - rd_ptr) == CAPACITY;
        is_hdr = bus.s_tdata == HEADER;
        is_ftr = bus.s_tdata == FOOTER;
        act    = ACT_NONE;
        if (bus.s_tvalid) begin
            case (state)
                BODY: begin
                    if (full)                                 act = ACT_ABORT;
                    else if (is_hdr)                          act = ACT_RESYNC;
                    else if (is_ftr)                          act = ACT_CLOSE;
                    else if (frame_len == LW'(MAX_WORDS - 1)) act = ACT_ABORT;
                    else                                      act = ACT_APPEND;
                end
                HUNT: begin
                    if (is_hdr)             act = full ? ACT_ABORT : ACT_OPEN;
                    else if (bus.s_tlast)   act = full ? ACT_ABORT : ACT_SINGLE;
                    else                    act = ACT_SYNC;
                end
                default: if (is_hdr) act = full ? ACT_ABORT : ACT_OPEN;
            endcase
        end
    end

    // A restarting HEADER overwrites the first slot of the abandoned frame.
    assign ram_we    = act inside {ACT_OPEN, ACT_SINGLE, ACT_APPEND, ACT_CLOSE, ACT_RESYNC};
    assign ram_waddr = (act == ACT_RESYNC) ? commit_ptr[DEPTH_LOG2-1:0] : wr_ptr[DEPTH_LOG2-1:0];

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state      <= HUNT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            frame_len  <= '0;
        end else begin
            case (act)
                ACT_OPEN: begin
                    wr_ptr    <= wr_ptr + PTR_ONE;
                    frame_len <= LW'(1);
                    state     <= BODY;
                end
                ACT_SINGLE: begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    commit_ptr <= wr_ptr + PTR_ONE;
                end
                ACT_APPEND: begin
                    wr_ptr    <= wr_ptr + PTR_ONE;
                    frame_len <= frame_len + LW'(1);
                end
                ACT_CLOSE: begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    commit_ptr <= wr_ptr + PTR_ONE;
                    frame_len  <= '0;
                    state      <= HUNT;
                end
                ACT_RESYNC: begin
                    wr_ptr    <= commit_ptr + PTR_ONE;
                    frame_len <= LW'(1);
                end
                ACT_ABORT: begin
                    wr_ptr    <= commit_ptr;
                    frame_len <= '0;
                    state     <= DROP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn || clear_stats) begin
            frames_committed <= '0;
            frames_dropped   <= '0;
            sync_errors      <= '0;
        end else begin
            if (act == ACT_CLOSE) frames_committed <= sat_inc(frames_committed);
            if (act == ACT_ABORT) frames_dropped   <= sat_inc(frames_dropped);
            if (act == ACT_SYNC || act == ACT_RESYNC) sync_errors <= sat_inc(sync_errors);
        end
    end

    sensor_frame_ram #(.AW(DEPTH_LOG2), .DW(33)) u_ram (
        .master_clock (master_clock),
        .we           (ram_we),
        .waddr        (ram_waddr),
        .wdata        ({bus.s_tlast, bus.s_tdata}),
        .re           (rd_en),
        .raddr        (rd_ptr[DEPTH_LOG2-1:0]),
        .q            (ram_q)
    );

    // RAM q holds its word while the output register is stalled, giving a two-entry read pipe.
    assign load  = rd_pend && (!out_vld || bus.m_tready);
    assign rd_en = (rd_ptr != commit_ptr) && (!rd_pend || load);

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            rd_pend  <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            rd_pend <= rd_en || (rd_pend && !load);
            if (load) begin
                out_vld  <= 1'b1;
                out_data <= ram_q[31:0];
                out_last <= ram_q[32];
            end else if (bus.m_tready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.m_tvalid = out_vld;
    assign bus.m_tdata  = out_data;
    assign bus.m_tlast  = out_last;

endmodule

// File: tb/tb_sensor_frame_buffer.sv
// Directed + randomized bench for sensor_frame_buffer against a frame-level queue model.
module tb_sensor_frame_buffer;
    import sensor_frame_pkg::*;

    localparam int DEPTH = 1024;
    localparam int MAXW  = 600;

    logic        master_clock = 1'b0;
    logic        resetn       = 1'b0;
    logic        clear_stats  = 1'b0;
    logic [10:0] fill_level;
    logic [15:0] frames_committed, frames_dropped, sync_errors;

    sensor_frame_buffer_if bus();

    sensor_frame_buffer #(.DEPTH_LOG2(10), .MAX_WORDS(MAXW)) dut (
        .master_clock     (master_clock),
        .resetn           (resetn),
        .bus              (bus),
        .clear_stats      (clear_stats),
        .fill_level       (fill_level),
        .frames_committed (frames_committed),
        .frames_dropped   (frames_dropped),
        .sync_errors      (sync_errors)
    );

    always #5 master_clock = ~master_clock;

    typedef enum {M_HUNT, M_BODY, M_DROP} mstate_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    int          m_commit = 0, m_drop = 0, m_sync = 0;
    mstate_t     mst = M_HUNT;
    logic [32:0] exp_q[$];
    logic [32:0] pend[$];
    logic [32:0] last_out = '0;
    bit          rnd_rdy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HEADER || w == FOOTER) w = w ^ 32'h1;
        return w;
    endfunction

    // Frame-level reference: words collect in pend until FOOTER releases them to exp_q.
    function automatic void model_word(input logic [31:0] d, input logic l);
        logic [32:0] w;
        bit full;
        w    = {l, d};
        full = (exp_q.size() + pend.size()) >= DEPTH;
        if (mst == M_BODY) begin
            if (full) begin
                pend.delete(); m_drop++; mst = M_DROP;
            end else if (d == HEADER) begin
                pend.delete(); pend.push_back(w); m_sync++;
            end else if (d == FOOTER) begin
                pend.push_back(w);
                foreach (pend[i]) exp_q.push_back(pend[i]);
                pend.delete(); m_commit++; mst = M_HUNT;
            end else begin
                pend.push_back(w);
                if (pend.size() == MAXW) begin
                    pend.delete(); m_drop++; mst = M_DROP;
                end
            end
        end else if (d == HEADER) begin
            if (full) begin m_drop++; mst = M_DROP; end
            else begin pend.push_back(w); mst = M_BODY; end
        end else if (mst == M_HUNT) begin
            if (!l) m_sync++;
            else if (full) begin m_drop++; mst = M_DROP; end
            else exp_q.push_back(w);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete(); pend.delete(); mst = M_HUNT;
        m_commit = 0; m_drop = 0; m_sync = 0;
    endfunction

    task automatic send(input logic [31:0] d, input logic l);
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        bus.s_tvalid = 1'b1;
        if (rnd_rdy) bus.m_tready = ($urandom_range(0, 7) != 0);
        model_word(d, l);
        @(posedge master_clock); #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int total, input bit rnd_last);
        send(HEADER, 1'b0);
        for (int i = 0; i < total - 2; i++) send(rnd_word(), rnd_last ? 1'($urandom_range(0, 1)) : 1'b0);
        send(FOOTER, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_rdy) bus.m_tready = ($urandom_range(0, 7) != 0);
            @(posedge master_clock); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.m_tready = 1'b1;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge master_clock); #1;
            n++;
        end
        idle(3);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_fill"}, fill_level, pend.size());
        check({tag, "_idle_vld"}, bus.m_tvalid, 0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_committed"}, frames_committed, sat16(m_commit));
        check({tag, "_dropped"}, frames_dropped, sat16(m_drop));
        check({tag, "_sync"}, sync_errors, sat16(m_sync));
    endtask

    always @(negedge master_clock) begin
        if (resetn && bus.m_tvalid && bus.m_tready) begin
            n_out++;
            last_out = {bus.m_tlast, bus.m_tdata};
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_word", last_out, exp_q.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n0;
        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;
        repeat (3) @(posedge master_clock);
        #1;
        check("rst_tvalid", bus.m_tvalid, 0);
        check("rst_tdata", bus.m_tdata, 0);
        check("rst_tlast", bus.m_tlast, 0);
        check("rst_fill", fill_level, 0);
        check("rst_tready", bus.s_tready, 1);
        check_stats("rst");
        resetn       = 1'b1;
        bus.m_tready = 1'b1;

        // Raw 515-word frame and first-word latency
        n0 = n_out;
        send(HEADER, 1'b0);
        send(rnd_word(), 1'b0);
        repeat (512) send(rnd_word(), 1'b0);
        send(FOOTER, 1'b1);
        check("lat_edge0", bus.m_tvalid, 0);
        @(posedge master_clock); #1;
        check("lat_edge1", bus.m_tvalid, 0);
        @(posedge master_clock); #1;
        check("lat_edge2", bus.m_tvalid, 1);
        drain("raw");
        check("raw_count", n_out - n0, 515);
        check("raw_committed", frames_committed, 1);

        // FOOTER then TERM single-word frame, then a stray word in HUNT
        send(HEADER, 1'b0);
        send(rnd_word(), 1'b0);
        send(FOOTER, 1'b0);
        send(TERM, 1'b1);
        send(32'h1234_5678, 1'b0);
        drain("term");
        check("term_last_word", last_out, {1'b1, TERM});
        check("junk_sync", sync_errors, 1);
        check_stats("term");

        // Restarting HEADER abandons the first partial frame
        n0 = n_out;
        send(HEADER, 1'b0);
        repeat (10) send(rnd_word(), 1'b0);
        send(HEADER, 1'b0);
        repeat (5) send(rnd_word(), 1'b0);
        send(FOOTER, 1'b1);
        drain("resync");
        check("resync_count", n_out - n0, 7);
        check("resync_sync", sync_errors, 2);

        // Over-length: 601 words without FOOTER
        n0 = n_out;
        send(HEADER, 1'b0);
        repeat (299) send(rnd_word(), 1'b0);
        check("ovl_fill_mid", fill_level, 300);
        repeat (301) send(rnd_word(), 1'b0);
        drain("ovl");
        check("ovl_count", n_out - n0, 0);
        check("ovl_dropped", frames_dropped, 1);
        check("ovl_fill_zero", fill_level, 0);

        // Exactly MAX_WORDS with FOOTER last is still a good frame
        n0 = n_out;
        send_frame(600, 1'b0);
        drain("max");
        check("max_count", n_out - n0, 600);
        check_stats("max");

        // clear_stats wins over a simultaneous sync error
        clear_stats = 1'b1;
        send(rnd_word(), 1'b0);
        m_commit = 0; m_drop = 0; m_sync = 0;
        clear_stats = 1'b0;
        check("clr_sync", sync_errors, 0);
        check("clr_committed", frames_committed, 0);
        check("clr_dropped", frames_dropped, 0);

        // Overflow while the DMA stalls: middle frame rolled back
        bus.m_tready = 1'b0;
        n0 = n_out;
        send_frame(512, 1'b0);
        send_frame(515, 1'b0);
        send_frame(512, 1'b0);
        idle(4);
        check("ovf_stalled", n_out - n0, 0);
        check("ovf_dropped", frames_dropped, 1);
        check("ovf_committed", frames_committed, 2);
        check("ovf_hold_vld", bus.m_tvalid, 1);
        check("ovf_hold_word", {bus.m_tlast, bus.m_tdata}, exp_q[0]);
        idle(3);
        check("ovf_hold_word2", {bus.m_tlast, bus.m_tdata}, exp_q[0]);
        drain("ovf");
        check("ovf_count", n_out - n0, 1024);
        check_stats("ovf");

        // Randomized traffic with a jittery DMA ready
        rnd_rdy = 1;
        for (int f = 0; f < 80; f++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(2, 26);
            case (kind)
                0, 1, 2, 3, 4: send_frame(len, 1'b1);
                5: send(rnd_word(), 1'b0);
                6: send(rnd_word(), 1'b1);
                7: begin
                    send(HEADER, 1'b0);
                    for (int i = 0; i < len; i++) send(rnd_word(), 1'b0);
                end
                8: send(HEADER, 1'b0);
                default: idle(len);
            endcase
        end
        send(FOOTER, 1'b0);
        rnd_rdy = 0;
        drain("rand");
        check_stats("rand");

        // Reset mid-frame with two committed frames waiting
        bus.m_tready = 1'b0;
        send_frame(6, 1'b0);
        send_frame(4, 1'b0);
        send(HEADER, 1'b0);
        send(rnd_word(), 1'b0);
        idle(2);
        resetn = 1'b0;
        model_reset();
        @(posedge master_clock); #1;
        check("mrst_tvalid", bus.m_tvalid, 0);
        check("mrst_fill", fill_level, 0);
        check_stats("mrst");
        resetn       = 1'b1;
        bus.m_tready = 1'b1;
        idle(5);
        check("mrst_quiet_vld", bus.m_tvalid, 0);
        check("mrst_quiet_fill", fill_level, 0);
        n0 = n_out;
        send_frame(5, 1'b0);
        drain("post_rst");
        check("post_rst_count", n_out - n0, 5);
        check_stats("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
